// File: rtl/led_scanner_pkg.sv
// Shared types and helpers for the LED scanner: the scan-mode encoding and
// a counter-width helper that stays legal when a divide ratio of 1 is chosen.
package led_scanner_pkg;

    typedef enum logic [1:0] {
        BOUNCE    = 2'd0,
        WRAP_UP   = 2'd1,
        WRAP_DOWN = 2'd2,
        HOLD      = 2'd3
    } scan_mode_t;

    // A register needs at least one bit even when it only ever holds zero.
    function automatic int unsigned cnt_width(input int unsigned span);
        return (span > 1) ? $clog2(span) : 1;
    endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Free-running divider: asserts tick for one cycle every TICK_DIV enabled
// cycles; the count freezes while en is low and resumes where it stopped.
module led_tick_gen
    import led_scanner_pkg::*;
#(
    parameter int unsigned TICK_DIV = 50_000_000
) (
    input  logic inclk,
    input  logic reset_n,
    input  logic en,
    output logic tick
);

    localparam int unsigned      CW       = cnt_width(TICK_DIV);
    localparam logic [CW-1:0]    CNT_LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] tick_cnt;

    // Combinational so the position update lands on the wrap cycle itself.
    assign tick = en && (tick_cnt == CNT_LAST);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge inclk or negedge reset_n) begin
        if (!reset_n) begin
            tick_cnt <= '0;
        end else if (en) begin
            tick_cnt <= (tick_cnt == CNT_LAST) ? '0 : tick_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/led_scanner.sv
// One-hot LED scanner: steps a lit position across N_LEDS outputs on each
// divider tick, in bounce, wrap-up, wrap-down or hold mode.
module led_scanner
    import led_scanner_pkg::*;
#(
    parameter int unsigned N_LEDS   = 8,
    parameter int unsigned TICK_DIV = 50_000_000
) (
    input  logic                      inclk,
    input  logic                      reset_n,
    input  logic                      en,
    input  logic [1:0]                mode,
    output logic [N_LEDS-1:0]         led,
    output logic [$clog2(N_LEDS)-1:0] pos,
    output logic                      dir,
    output logic                      step
);

    localparam int unsigned        PW      = $clog2(N_LEDS);
    localparam logic [PW-1:0]      POS_TOP = PW'(N_LEDS - 1);
    localparam logic [N_LEDS-1:0]  LED_ONE = N_LEDS'(1);

    logic          tick;
    logic [PW-1:0] next_pos;
    logic          next_dir;

    led_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .inclk   (inclk),
        .reset_n (reset_n),
        .en      (en),
        .tick    (tick)
    );

    // NOTE: every always_comb output gets a default first, so no path leaves
    // a signal unassigned and no latch is inferred.
    always_comb begin
        next_pos = pos;
        next_dir = dir;
        case (scan_mode_t'(mode))
            BOUNCE: begin
                // Ends reverse immediately: the end LED is lit for one step only.
                if (dir) begin
                    if (pos == POS_TOP) begin
                        next_dir = 1'b0;
                        next_pos = POS_TOP - PW'(1);
                    end else begin
                        next_pos = pos + PW'(1);
                    end
                end else begin
                    if (pos == '0) begin
                        next_dir = 1'b1;
                        next_pos = PW'(1);
                    end else begin
                        next_pos = pos - PW'(1);
                    end
                end
            end
            WRAP_UP:   next_pos = (pos == POS_TOP) ? '0 : pos + PW'(1);
            WRAP_DOWN: next_pos = (pos == '0) ? POS_TOP : pos - PW'(1);
            HOLD:      next_pos = pos;
        endcase
    end

    // led is registered alongside pos so the two can never disagree.
    always_ff @(posedge inclk or negedge reset_n) begin
        if (!reset_n) begin
            pos  <= '0;
            dir  <= 1'b1;
            led  <= LED_ONE;
            step <= 1'b0;
        end else begin
            step <= tick;
            if (tick) begin
                pos <= next_pos;
                dir <= next_dir;
                led <= LED_ONE << next_pos;
            end
        end
    end

endmodule
